spu_inst_decode: RTL and testbench

//  Decodes 32-bit SPU instruction words into defines_pkg::Opcodes plus operand fields.

---
 rtl/defines_pkg.sv | 44 ++++
 rtl/spu_opcode_match.sv | 45 ++++
 rtl/spu_inst_decode.sv | 122 ++++++++++++
 tb/tb_spu_inst_decode.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/defines_pkg.sv
// Shared SPU decode types: opcode enum (short opcodes zero-extended to 11 bits),
// instruction formats and the decoded-instruction record.
package defines_pkg;

    typedef enum logic [10:0] {
        INVALID                       = 11'h000,
        // 11-bit opcodes, inst[31:21]
        ADD_WORD                      = 11'h0C0,
        ADD_HALFWORD                  = 11'h0C8,
        SUBTRACT_FROM_WORD            = 11'h040,
        AND                           = 11'h0C1,
        OR                            = 11'h041,
        EXCLUSIVE_OR                  = 11'h241,
        NO_OPERATION_EXECUTE          = 11'h201,
        SHIFT_LEFT_HALFWORD_IMMEDIATE = 11'h07F,
        // 9-bit opcodes, inst[31:23]
        IMMEDIATE_LOAD_WORD           = 11'h081,
        IMMEDIATE_LOAD_HALFWORD       = 11'h083,
        // 8-bit opcodes, inst[31:24]
        ADD_WORD_IMMEDIATE            = 11'h01C,
        ADD_HALFWORD_IMMEDIATE        = 11'h01D,
        AND_WORD_IMMEDIATE            = 11'h014,
        OR_WORD_IMMEDIATE             = 11'h004,
        SUBTRACT_FROM_WORD_IMMEDIATE  = 11'h00C,
        // 7-bit opcodes, inst[31:25]
        IMMEDIATE_LOAD_ADDRESS        = 11'h021
    } Opcodes;

    typedef enum logic [2:0] {FMT_RR, FMT_RI7, FMT_RI10, FMT_RI16, FMT_RI18} inst_fmt_e;

    localparam int DEC_REG_W = 7;
    localparam int DEC_IMM_W = 32;

    typedef struct packed {
        Opcodes                 opcode;
        inst_fmt_e              fmt;
        logic [DEC_REG_W-1:0]   rt;
        logic [DEC_REG_W-1:0]   ra;
        logic [DEC_REG_W-1:0]   rb;
        logic [DEC_IMM_W-1:0]   imm;
        logic                   illegal;
    } decoded_inst_t;

endpackage

// File: rtl/spu_opcode_match.sv
// Combinational opcode recovery from inst[31:21]: tries 11-, 9-, 8- then 7-bit
// opcode classes in that priority order; no hit flags the word illegal.
module spu_opcode_match
    import defines_pkg::*;
(
    input  logic [10:0] op_field,
    output Opcodes      opcode,
    output inst_fmt_e   fmt,
    output logic        illegal
);

    Opcodes op11, op9, op8, op7;

    assign op11 = Opcodes'(op_field);
    assign op9  = Opcodes'({2'b00,   op_field[10:2]});
    assign op8  = Opcodes'({3'b000,  op_field[10:3]});
    assign op7  = Opcodes'({4'b0000, op_field[10:4]});

    always_comb begin
        opcode  = INVALID;
        fmt     = FMT_RR;
        illegal = 1'b0;
        if (op11 inside {ADD_WORD, ADD_HALFWORD, SUBTRACT_FROM_WORD, AND, OR,
                         EXCLUSIVE_OR, NO_OPERATION_EXECUTE}) begin
            opcode = op11;
        end else if (op11 == SHIFT_LEFT_HALFWORD_IMMEDIATE) begin
            opcode = op11;
            fmt    = FMT_RI7;
        end else if (op9 inside {IMMEDIATE_LOAD_WORD, IMMEDIATE_LOAD_HALFWORD}) begin
            opcode = op9;
            fmt    = FMT_RI16;
        end else if (op8 inside {ADD_WORD_IMMEDIATE, ADD_HALFWORD_IMMEDIATE,
                                 AND_WORD_IMMEDIATE, OR_WORD_IMMEDIATE,
                                 SUBTRACT_FROM_WORD_IMMEDIATE}) begin
            opcode = op8;
            fmt    = FMT_RI10;
        end else if (op7 == IMMEDIATE_LOAD_ADDRESS) begin
            opcode = op7;
            fmt    = FMT_RI18;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/spu_inst_decode.sv
// Two-stage valid/ready SPU instruction decoder: S1 holds the raw word, S2 the
// decoded record. Define SPU_DECODE_PERF_EN to add saturating perf counters.
module spu_inst_decode
    import defines_pkg::*;
#(
    parameter int REG_ADDR_W = 7,
    parameter int IMM_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output Opcodes                out_opcode,
    output inst_fmt_e             out_fmt,
    output logic [REG_ADDR_W-1:0] out_rt,
    output logic [REG_ADDR_W-1:0] out_ra,
    output logic [REG_ADDR_W-1:0] out_rb,
    output logic [IMM_W-1:0]      out_imm,
    output logic                  out_illegal
`ifdef SPU_DECODE_PERF_EN
    ,
    output logic [31:0]           perf_decoded,
    output logic [31:0]           perf_illegal
`endif
);

    logic [2:1]    vld_pipe;
    logic [31:0]   s1_inst;
    decoded_inst_t s1_dec, s2_q;
    Opcodes        m_op;
    inst_fmt_e     m_fmt;
    logic          m_ill;
    logic          accept, advance, drain;

    assign drain    = vld_pipe[2] && out_ready;
    assign advance  = vld_pipe[1] && (!vld_pipe[2] || out_ready);
    assign in_ready = !vld_pipe[1] || !vld_pipe[2] || out_ready;
    assign accept   = in_valid && in_ready;

    spu_opcode_match u_match (
        .op_field (s1_inst[31:21]),
        .opcode   (m_op),
        .fmt      (m_fmt),
        .illegal  (m_ill)
    );

    // Illegal words leave every field at zero but still flow through S2.
    always_comb begin
        s1_dec         = '0;
        s1_dec.illegal = m_ill;
        if (!m_ill) begin
            s1_dec.opcode = m_op;
            s1_dec.fmt    = m_fmt;
            s1_dec.rt     = s1_inst[6:0];
            case (m_fmt)
                FMT_RR: begin
                    s1_dec.ra = s1_inst[13:7];
                    s1_dec.rb = s1_inst[20:14];
                end
                FMT_RI7: begin
                    s1_dec.ra  = s1_inst[13:7];
                    s1_dec.imm = {{25{s1_inst[20]}}, s1_inst[20:14]};
                end
                FMT_RI10: begin
                    s1_dec.ra  = s1_inst[13:7];
                    s1_dec.imm = {{22{s1_inst[23]}}, s1_inst[23:14]};
                end
                FMT_RI16: s1_dec.imm = {{16{s1_inst[22]}}, s1_inst[22:7]};
                FMT_RI18: s1_dec.imm = {14'b0, s1_inst[24:7]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_inst  <= '0;
            s2_q     <= '0;
        end else begin
            if (accept)
                s1_inst <= in_inst;
            vld_pipe[1] <= accept || (vld_pipe[1] && !advance);
            // S2 only reloads when empty or draining, so a stalled record holds.
            if (advance)
                s2_q <= s1_dec;
            vld_pipe[2] <= advance || (vld_pipe[2] && !out_ready);
        end
    end

    assign out_valid   = vld_pipe[2];
    assign out_opcode  = s2_q.opcode;
    assign out_fmt     = s2_q.fmt;
    assign out_rt      = REG_ADDR_W'(s2_q.rt);
    assign out_ra      = REG_ADDR_W'(s2_q.ra);
    assign out_rb      = REG_ADDR_W'(s2_q.rb);
    assign out_imm     = IMM_W'(s2_q.imm);
    assign out_illegal = s2_q.illegal;

`ifdef SPU_DECODE_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded <= '0;
            perf_illegal <= '0;
        end else if (drain) begin
            if (s2_q.illegal) begin
                if (perf_illegal != 32'hFFFF_FFFF)
                    perf_illegal <= perf_illegal + 32'd1;
            end else if (perf_decoded != 32'hFFFF_FFFF) begin
                perf_decoded <= perf_decoded + 32'd1;
            end
        end
    end
`else
    logic unused_drain;
    assign unused_drain = drain;
`endif

endmodule

// File: tb/tb_spu_inst_decode.sv
// Bench for spu_inst_decode: directed ISA vectors, stall/reset scenarios and
// random traffic checked against a table-driven decode and occupancy model.
module tb_spu_inst_decode;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [31:0] in_inst;
    logic        in_ready, out_valid, out_illegal;
    logic [10:0] out_opcode;
    logic [2:0]  out_fmt;
    logic [6:0]  out_rt, out_ra, out_rb;
    logic [31:0] out_imm;
`ifdef SPU_DECODE_PERF_EN
    logic [31:0] perf_decoded, perf_illegal;
`endif

    always #5 clk = ~clk;

    spu_inst_decode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_fmt(out_fmt), .out_rt(out_rt),
        .out_ra(out_ra), .out_rb(out_rb), .out_imm(out_imm),
        .out_illegal(out_illegal)
`ifdef SPU_DECODE_PERF_EN
        , .perf_decoded(perf_decoded), .perf_illegal(perf_illegal)
`endif
    );

    // ISA opcode table: length in bits, value, format (0=RR 1=RI7 2=RI10 3=RI16 4=RI18)
    int unsigned tab_len [16] = '{11, 11, 11, 11, 11, 11, 11, 11, 9, 9, 8, 8, 8, 8, 8, 7};
    int unsigned tab_val [16] = '{'h0C0, 'h0C8, 'h040, 'h0C1, 'h041, 'h241, 'h201, 'h07F,
                                  'h081, 'h083, 'h01C, 'h01D, 'h014, 'h004, 'h00C, 'h021};
    int unsigned tab_fmt [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 2, 2, 2, 2, 2, 4};
    int unsigned prio_len [4] = '{11, 9, 8, 7};

    typedef struct { logic [67:0] rec; int cyc; } exp_t;
    exp_t        q[$];
    logic [67:0] dir_exp[$];
    int          n_tests = 0, n_fail = 0, cyc = 0;
    logic        prev_stall = 1'b0;
    logic [67:0] prev_rec;
    int unsigned m_dec = 0, m_ill = 0;

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] sx(input int unsigned v, input int n);
        return (v >= (32'd1 << (n - 1))) ? v - (32'd1 << n) : v;
    endfunction

    function automatic logic [67:0] decode_ref(input logic [31:0] w);
        int f = -1;
        int unsigned fmt, rt, ra, rb;
        logic [31:0] imm;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                if (f < 0 && tab_len[i] == prio_len[p] && (w >> (32 - prio_len[p])) == tab_val[i])
                    f = i;
        if (f < 0) return 68'd1;
        fmt = tab_fmt[f];
        rt  = w & 'h7F;
        ra  = (fmt <= 2) ? (w >> 7) & 'h7F : 0;
        rb  = (fmt == 0) ? (w >> 14) & 'h7F : 0;
        case (fmt)
            1: imm = sx((w >> 14) & 'h7F, 7);
            2: imm = sx((w >> 14) & 'h3FF, 10);
            3: imm = sx((w >> 7) & 'hFFFF, 16);
            4: imm = (w >> 7) & 'h3FFFF;
            default: imm = 0;
        endcase
        return {tab_val[f][10:0], fmt[2:0], rt[6:0], ra[6:0], rb[6:0], imm, 1'b0};
    endfunction

    function automatic logic [67:0] dut_rec();
        return {out_opcode, out_fmt, out_rt, out_ra, out_rb, out_imm, out_illegal};
    endfunction

    function automatic logic [31:0] rand_word();
        int i;
        if ($urandom_range(0, 9) < 3) return $urandom();
        i = $urandom_range(0, 15);
        return (tab_val[i] << (32 - tab_len[i])) |
               ($urandom() & ((32'd1 << (32 - tab_len[i])) - 32'd1));
    endfunction

    // One cycle: inputs already driven at the negedge; sample, score, advance.
    task automatic step(output logic acc);
        logic [67:0] r;
        logic ov, ir;
        #1;
        r  = dut_rec();
        ov = out_valid;
        ir = in_ready;
        chk("out_valid", ov, q.size() > 0 && cyc >= q[0].cyc + 2);
        chk("in_ready", ir, !(q.size() == 2 && !out_ready));
        if (prev_stall) chk("stable", r, prev_rec);
`ifdef SPU_DECODE_PERF_EN
        chk("perf_decoded", perf_decoded, m_dec);
        chk("perf_illegal", perf_illegal, m_ill);
`endif
        if (ov && out_ready) begin
            if (q.size() == 0) chk("spurious", ov, 0);
            else begin
                chk("rec", r, q[0].rec);
                if (q[0].rec[0]) m_ill++; else m_dec++;
                void'(q.pop_front());
            end
        end
        acc = in_valid && ir;
        if (acc) q.push_back('{rec: (dir_exp.size() > 0) ? dir_exp.pop_front() : decode_ref(in_inst), cyc: cyc});
        prev_stall = ov && !out_ready;
        prev_rec   = r;
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_words(input logic [31:0] w[$], input int stall_lo, input int stall_hi);
        int k = 0, t0 = cyc, guard = 0;
        logic acc;
        while ((k < w.size() || q.size() > 0) && guard < 200) begin
            in_valid  = (k < w.size());
            in_inst   = in_valid ? w[k] : 32'h0;
            out_ready = !((cyc - t0) >= stall_lo && (cyc - t0) <= stall_hi);
            step(acc);
            if (acc) k++;
            guard++;
        end
        if (guard >= 200) chk("run_timeout", guard, 0);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset_checks(input string tag);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_rec"}, dut_rec(), 68'd0);
`ifdef SPU_DECODE_PERF_EN
        chk({tag, "_perf"}, {perf_decoded, perf_illegal}, 64'd0);
`endif
        q.delete();
        prev_stall = 1'b0;
        m_dec = 0;
        m_ill = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] w[$];
        logic acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = 32'h0;
        @(negedge clk);
        pulse_reset_checks("reset");

        // ISA vectors with hand-derived records
        w = '{32'h18008083, 32'h1CFFC286, 32'h43FFFF89, 32'hFFE00000, 32'h40C00085, 32'h0FF00381};
        dir_exp = '{{11'h0C0, 3'd0, 7'd3, 7'd1, 7'd2, 32'h0000_0000, 1'b0},
                    {11'h01C, 3'd2, 7'd6, 7'd5, 7'd0, 32'hFFFF_FFFF, 1'b0},
                    {11'h021, 3'd4, 7'd9, 7'd0, 7'd0, 32'h0003_FFFF, 1'b0},
                    68'd1,
                    {11'h081, 3'd3, 7'd5, 7'd0, 7'd0, 32'hFFFF_8001, 1'b0},
                    {11'h07F, 3'd1, 7'd1, 7'd7, 7'd0, 32'hFFFF_FFC0, 1'b0}};
        run_words(w, 1, 0);
`ifdef SPU_DECODE_PERF_EN
        chk("perf_illegal_after_dir", perf_illegal, 1);
`endif

        // Four back-to-back words with a consumer stall on cycles 3..6
        w = '{32'h18008083, 32'h40C00085, 32'h1CFFC286, 32'h43FFFF89};
        run_words(w, 3, 6);

        // Reset with both stages occupied, then a clean first word
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_inst = rand_word();
            step(acc);
        end
        pulse_reset_checks("midreset");
        w = '{32'h18008083};
        run_words(w, 1, 0);

        // Random traffic; a refused word is held until taken
        in_valid = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_inst  = rand_word();
            end
            out_ready = (i % 97 < 10) ? 1'b0 : ($urandom_range(0, 3) != 0);
            step(acc);
        end
        in_valid = 1'b0;
        w.delete();
        run_words(w, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
